// File: rtl/pc_checkpoint_monitor.sv
// pc_checkpoint_monitor: walks a list of PC checkpoints, compares dmemout
// one settle cycle after each is reached, and guards the run with a watchdog.
module pc_checkpoint_monitor #(
    parameter int NUM_CHK  = 2,
    parameter int WD_LIMIT = 255,
    parameter int PC_W     = 64,
    parameter int DATA_W   = 64
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      start,
    input  logic [NUM_CHK*PC_W-1:0]   chk_pc,
    input  logic [NUM_CHK*DATA_W-1:0] chk_expect,
    input  logic [PC_W-1:0]           currentpc,
    input  logic [DATA_W-1:0]         dmemout,
    output logic                      busy,
    output logic                      done,
    output logic                      all_pass,
    output logic [7:0]                pass_count,
    output logic [NUM_CHK-1:0]        fail_vec,
    output logic [7:0]                chk_idx,
    output logic [DATA_W-1:0]         last_data,
    output logic                      watchdog_exp
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_PC,
        S_SETTLE,
        S_DONE,
        S_TIMEOUT
    } state_e;

    localparam logic [15:0] WD_MAX   = 16'(WD_LIMIT);
    localparam logic [7:0]  LAST_IDX = 8'(NUM_CHK - 1);
    localparam logic [7:0]  ALL_CNT  = 8'(NUM_CHK);

    state_e              state_q, state_d;
    logic [7:0]          pass_q, pass_d;
    logic [NUM_CHK-1:0]  fail_q, fail_d;
    logic [7:0]          idx_q, idx_d;
    logic [DATA_W-1:0]   last_q, last_d;
    logic [15:0]         wd_q, wd_d;
    logic                wdx_q, wdx_d;

    logic [PC_W-1:0]     cur_pc;
    logic [DATA_W-1:0]   cur_exp;
    logic [15:0]         wd_inc;
    logic                wd_hit;

    assign wd_inc = wd_q + 16'd1;
    assign wd_hit = (wd_inc == WD_MAX);

    // Select address and expected data of the active checkpoint
    always_comb begin
        cur_pc  = '0;
        cur_exp = '0;
        for (int i = 0; i < NUM_CHK; i++) begin
            if (idx_q == 8'(i)) begin
                cur_pc  = chk_pc[i*PC_W +: PC_W];
                cur_exp = chk_expect[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state logic: sequencing, compare, watchdog
    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        idx_d   = idx_q;
        last_d  = last_q;
        wd_d    = wd_q;
        wdx_d   = wdx_q;
        case (state_q)
            S_IDLE, S_DONE, S_TIMEOUT: begin
                if (start) begin
                    pass_d  = '0;
                    fail_d  = '0;
                    idx_d   = '0;
                    last_d  = '0;
                    wd_d    = '0;
                    wdx_d   = 1'b0;
                    state_d = S_WAIT_PC;
                end
            end
            S_WAIT_PC, S_SETTLE: begin
                wd_d = wd_inc;
                if (wd_hit) begin
                    // Watchdog wins; remaining checkpoints count as failed
                    wdx_d   = 1'b1;
                    state_d = S_TIMEOUT;
                    for (int i = 0; i < NUM_CHK; i++) begin
                        if (8'(i) >= idx_q) begin
                            fail_d[i] = 1'b1;
                        end
                    end
                end else if (state_q == S_WAIT_PC) begin
                    if (currentpc >= cur_pc) begin
                        state_d = S_SETTLE;
                    end
                end else begin
                    last_d = dmemout;
                    if (dmemout == cur_exp) begin
                        if (pass_q != 8'hFF) begin
                            pass_d = pass_q + 8'd1;
                        end
                    end else begin
                        for (int i = 0; i < NUM_CHK; i++) begin
                            if (idx_q == 8'(i)) begin
                                fail_d[i] = 1'b1;
                            end
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = S_WAIT_PC;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= S_IDLE;
            pass_q  <= '0;
            fail_q  <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            wd_q    <= '0;
            wdx_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
            wdx_q   <= wdx_d;
        end
    end

    assign busy         = (state_q == S_WAIT_PC) || (state_q == S_SETTLE);
    assign done         = (state_q == S_DONE) || (state_q == S_TIMEOUT);
    assign all_pass     = done & ~wdx_q & (pass_q == ALL_CNT);
    assign pass_count   = pass_q;
    assign fail_vec     = fail_q;
    assign chk_idx      = idx_q;
    assign last_data    = last_q;
    assign watchdog_exp = wdx_q;

endmodule
